// File: rtl/program_counter.sv
// Instruction-fetch address register for the single-cycle datapath.
// Chooses the next address by priority: load, stall, PC-relative branch, sequential increment.
module program_counter #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned STEP     = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              load,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_off,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              wrapped,
  output logic              held
);

  localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_W = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inc_addr, br_addr;
  logic              wrapped_q, wrapped_d;
  logic              held_q, held_d;

  always_comb begin
    inc_addr  = pc_q + STEP_W;
    br_addr   = inc_addr + branch_off;
    pc_d      = inc_addr;
    wrapped_d = 1'b0;
    held_d    = 1'b0;
    if (load) begin
      pc_d = pc_in;
    end else if (stall) begin
      pc_d   = pc_q;
      held_d = 1'b1;
    end else if (branch_en) begin
      pc_d = br_addr;
      // Backward offsets cross below zero when the result lands above the fall-through address.
      if (branch_off[ADDR_W-1]) begin
        wrapped_d = (br_addr > inc_addr);
      end else begin
        wrapped_d = (br_addr < pc_q);
      end
    end else begin
      pc_d      = inc_addr;
      wrapped_d = (inc_addr < pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_W;
      wrapped_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
      held_q    <= held_d;
    end
  end

  assign pc_out  = pc_q;
  assign pc_next = pc_d;
  assign wrapped = wrapped_q;
  assign held    = held_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an integer-arithmetic model.
module tb_program_counter;

  localparam int ADDR_W = 6;
  localparam int STEP   = 1;
  localparam int MOD    = 1 << ADDR_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc_in = '0;
  logic              load  = 1'b0;
  logic              stall = 1'b0;
  logic              branch_en  = 1'b0;
  logic [ADDR_W-1:0] branch_off = '0;
  logic [ADDR_W-1:0] pc_out, pc_next;
  logic              wrapped, held;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int m_pc   = 0;
  int m_wrap = 0;
  int m_held = 0;

  program_counter #(.ADDR_W(ADDR_W), .STEP(STEP), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .load(load), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off),
    .pc_out(pc_out), .pc_next(pc_next), .wrapped(wrapped), .held(held)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int soff(input int off);
    return (off >= MOD/2) ? off - MOD : off;
  endfunction

  function automatic int mnext(input int pc, input int ld, input int st, input int br,
                               input int off, input int pin);
    int t;
    if (ld != 0) return pin;
    if (st != 0) return pc;
    t = pc + STEP + ((br != 0) ? soff(off) : 0);
    return ((t % MOD) + MOD) % MOD;
  endfunction

  function automatic int mwrap(input int pc, input int ld, input int st, input int br,
                               input int off, input int pin);
    int inc, res;
    if (ld != 0 || st != 0) return 0;
    inc = (pc + STEP) % MOD;
    res = mnext(pc, ld, st, br, off, pin);
    if (br != 0 && soff(off) < 0) return (res > inc) ? 1 : 0;
    return (res < pc) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc   <= 0;
      m_wrap <= 0;
      m_held <= 0;
    end else begin
      m_pc   <= mnext(m_pc, int'(load), int'(stall), int'(branch_en), int'(branch_off), int'(pc_in));
      m_wrap <= mwrap(m_pc, int'(load), int'(stall), int'(branch_en), int'(branch_off), int'(pc_in));
      m_held <= (stall && !load) ? 1 : 0;
    end
  end

  // Per-cycle comparison, mid-cycle when outputs and inputs are stable.
  always @(negedge clk) begin
    check("pc_out",  int'(pc_out),  m_pc);
    check("wrapped", int'(wrapped), m_wrap);
    check("held",    int'(held),    m_held);
    check("pc_next", int'(pc_next),
          mnext(m_pc, int'(load), int'(stall), int'(branch_en), int'(branch_off), int'(pc_in)));
  end

  task automatic go(input logic ld, input logic st, input logic br,
                    input int off, input int pin);
    @(posedge clk);
    #2;
    load       = ld;
    stall      = st;
    branch_en  = br;
    branch_off = ADDR_W'(off);
    pc_in      = ADDR_W'(pin);
  endtask

  task automatic idle();
    go(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    // 1. reset
    #15;
    check("rst_pc", int'(pc_out), 0);
    check("rst_wrapped", int'(wrapped), 0);
    check("rst_held", int'(held), 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(1'b1, 1'b0, 1'b0, 0, 'h15);
    idle();
    check("pre_rst_pc", int'(pc_out), 'h15);
    #1 rst_n = 1'b0;
    #1 check("async_rst_pc", int'(pc_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); check("rel_pc1", int'(pc_out), 1);
    idle(); check("rel_pc2", int'(pc_out), 2);
    idle(); check("rel_pc3", int'(pc_out), 3);

    // 2. load and priority
    go(1'b1, 1'b0, 1'b0, 0, 'h2A);
    idle(); check("load_pc", int'(pc_out), 'h2A);
    idle(); check("load_inc", int'(pc_out), 'h2B);
    go(1'b1, 1'b1, 1'b1, 5, 'h11);
    idle(); check("load_wins", int'(pc_out), 'h11);
    check("load_wins_held", int'(held), 0);

    // 3. wrap at top of address space
    go(1'b1, 1'b0, 1'b0, 0, 'h3F);
    idle(); check("wrap_pre", int'(pc_out), 'h3F);
    idle(); check("wrap_pc", int'(pc_out), 0);
    check("wrap_flag", int'(wrapped), 1);
    idle(); check("wrap_next", int'(pc_out), 1);
    check("wrap_clr", int'(wrapped), 0);

    // 4. branches
    go(1'b1, 1'b0, 1'b0, 0, 'h10);
    go(1'b0, 1'b0, 1'b1, 'h04, 0);
    check("br_pre", int'(pc_out), 'h10);
    idle(); check("br_fwd", int'(pc_out), 'h15);
    check("br_fwd_wrap", int'(wrapped), 0);
    go(1'b1, 1'b0, 1'b0, 0, 'h02);
    go(1'b0, 1'b0, 1'b1, 'h3C, 0);
    check("brb_pre", int'(pc_out), 'h02);
    idle(); check("br_back", int'(pc_out), 'h3F);
    check("br_back_wrap", int'(wrapped), 1);

    // 5. stall
    go(1'b1, 1'b0, 1'b0, 0, 'h08);
    go(1'b0, 1'b1, 1'b0, 0, 0);
    check("st_pre", int'(pc_out), 'h08);
    go(1'b0, 1'b1, 1'b0, 0, 0);
    check("st_1", int'(pc_out), 'h08); check("st_held1", int'(held), 1);
    go(1'b0, 1'b1, 1'b1, 7, 0);
    check("st_2", int'(pc_out), 'h08); check("st_held2", int'(held), 1);
    idle();
    check("st_br", int'(pc_out), 'h08); check("st_held3", int'(held), 1);
    idle();
    check("st_rel", int'(pc_out), 'h09); check("st_held_clr", int'(held), 0);

    // 6. pc_next is combinational and pc_out only moves at edges
    go(1'b1, 1'b0, 1'b0, 0, 'h20);
    idle();
    check("nx_pc", int'(pc_out), 'h20);
    #1 check("nx_idle", int'(pc_next), 'h21);
    load = 1'b1; pc_in = 6'h05;
    #1 check("nx_load", int'(pc_next), 'h05);
    load = 1'b0; stall = 1'b1;
    #1 check("nx_stall", int'(pc_next), 'h20);
    stall = 1'b0; branch_en = 1'b1; branch_off = 6'h3E;
    #1 check("nx_brback", int'(pc_next), 'h1F);
    branch_off = 6'h08;
    #1 check("nx_brfwd", int'(pc_next), 'h29);
    check("nx_pc_hold", int'(pc_out), 'h20);
    idle();
    check("nx_after", int'(pc_out), 'h29);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      go(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
         ($urandom_range(0, 2) == 0), int'($urandom_range(0, MOD-1)),
         int'($urandom_range(0, MOD-1)));
      if ($urandom_range(0, 59) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    idle();
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
